pattern_det: RTL and testbench
==============================

PATTERN_DET -- requirements
Module: pattern_det

Interface
REQ-001 Parameter PAT_W, default 8: pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: match counter width.
REQ-003 Parameter [PAT_W-1:0] RST_PATTERN, default alternating 0101...: pattern loaded at reset.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  asynchronous assert, active-low reset.
REQ-006 bit_stream  in  1  serial data bit.
REQ-007 bit_valid  in  1  bit_stream is sampled only when high.
REQ-008 start  in  1  arm pulse.
REQ-009 stop  in  1  disarm pulse.
REQ-010 cfg_load  in  1  load cfg_pattern, cfg_mask and cfg_mode.
REQ-011 cfg_pattern  in  PAT_W  pattern; bit PAT_W-1 is the first bit received.
REQ-012 cfg_mask  in  PAT_W  1 = compare bit, 0 = don't care.
REQ-013 cfg_mode  in  2  bit0 = overlap enable, bit1 = one-shot.
REQ-014 found  out  1  one-cycle match pulse.
REQ-015 match_count  out  CNT_W  saturating count of matches since start.
REQ-016 armed  out  1  high in FILL or HUNT.

Function
REQ-017 The FSM SHALL have states IDLE, FILL and HUNT.
REQ-018 IDLE SHALL go to FILL on start, clearing history, fill count and match_count.
REQ-019 In FILL, each valid bit SHALL shift into history LSB and increment fill count.
REQ-020 FILL SHALL go to HUNT on the cycle the PAT_W-th valid bit is accepted; that bit SHALL also be compared.
REQ-021 A match SHALL be (history_next & mask) == (pattern & mask), evaluated only on a valid-bit cycle with fill count reaching or at PAT_W.
REQ-022 found SHALL assert exactly one cycle after the clock edge that accepts the completing bit (latency 1).
REQ-023 found SHALL be low in all other cycles.
REQ-024 With overlap = 1, the state SHALL stay in HUNT after a match, so shared bits count toward the next match.
REQ-025 With overlap = 0, a match SHALL clear the fill count and return the FSM to FILL.
REQ-026 With one-shot = 1, a match SHALL take the FSM to IDLE; found and match_count SHALL still update.
REQ-027 match_count SHALL increment by 1 per match and saturate at all-ones (no wrap).
REQ-028 Invalid cycles (bit_valid = 0) SHALL leave history, fill count and the FSM unchanged.
REQ-029 stop SHALL force IDLE from any state on the next edge; match_count SHALL hold.
REQ-030 If stop and start are both high, stop SHALL win.
REQ-031 A match on the same cycle as stop SHALL NOT be reported.
REQ-032 cfg_load SHALL take effect only in IDLE; in other states it SHALL be ignored.
REQ-033 cfg_load together with start in IDLE SHALL load the configuration first; the new configuration applies to the first bit.
REQ-034 An all-zero mask SHALL match on every valid bit once the fill count reaches PAT_W.

Reset
REQ-035 rst_n low SHALL asynchronously set state = IDLE, found = 0, match_count = 0, armed = 0, history = 0 and fill count = 0.
REQ-036 Reset SHALL also set pattern = RST_PATTERN, mask = all-ones and mode = 2'b00.
REQ-037 Reset mid-operation SHALL discard partial history; after reset, detection resumes only on a new start.

Structure
REQ-038 Package pattern_pkg SHALL hold the state enum (one-hot encoded), the cfg_mode bit-index constants and the default mode constant.
REQ-039 The saturating counter SHALL be a sub-module named sat_counter, with parameter W and inputs clr and inc.
REQ-040 The fill counter SHALL be $clog2(PAT_W+1) bits wide.

Verification (PAT_W = 4)
REQ-041 Pattern 0101, mask 1111, overlap 1; stream 0,1,0,1,0,1 -> found after bits 4 and 6; match_count = 2.
REQ-042 Same stream with overlap 0 -> found after bit 4 only; match_count = 1.
REQ-043 Pattern 1000, mask 1001, one-shot; stream 1,1,1,0 -> one found; FSM returns to IDLE; armed = 0.
REQ-044 bit_valid toggled 0/1 during 0,1,0,1 -> found exactly once, 1 cycle after the 4th valid bit.
REQ-045 CNT_W = 2; mask 0000, overlap 1; 10 valid bits -> match_count saturates at 3.
REQ-046 rst_n pulsed low after 3 bits, then start and 0,1,0,1 -> no found before reset; one found after the new bits; pattern = RST_PATTERN.

Source files
------------

// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pattern_pkg
// Description : Shared FSM encoding and cfg_mode field positions for
//               pattern_det.
// Revision    : 1.0 - initial release
// ============================================================================
package pattern_pkg;

  localparam int c_ST_W = 3;

  localparam logic [c_ST_W-1:0] c_ST_IDLE = 3'b001;
  localparam logic [c_ST_W-1:0] c_ST_FILL = 3'b010;
  localparam logic [c_ST_W-1:0] c_ST_HUNT = 3'b100;

  typedef enum logic [c_ST_W-1:0] {
    ST_IDLE = c_ST_IDLE,
    ST_FILL = c_ST_FILL,
    ST_HUNT = c_ST_HUNT
  } state_e;

  localparam int         c_MODE_OVERLAP = 0;
  localparam int         c_MODE_ONESHOT = 1;
  localparam logic [1:0] c_MODE_DEFAULT = 2'b00;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up counter that sticks at all-ones; clr has priority over inc.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pattern_det.sv
`default_nettype none
// ============================================================================
// Module      : pattern_det
// Description : Serial masked pattern detector with overlap / one-shot modes
//               and a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_det
  import pattern_pkg::*;
#(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'({16{2'b01}})
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_stream,
  input  logic             bit_valid,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [1:0]       cfg_mode,
  output logic             found,
  output logic [CNT_W-1:0] match_count,
  output logic             armed
);

  localparam int                FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] c_FILL_LAST = FILL_W'(PAT_W - 1);

  state_e            r_state;
  logic [PAT_W-1:0]  r_history;
  logic [PAT_W-1:0]  r_pattern;
  logic [PAT_W-1:0]  r_mask;
  logic [1:0]        r_mode;
  logic [FILL_W-1:0] r_fill;
  logic              r_found;

  logic             w_hunting;
  logic             w_accept;
  logic             w_complete;
  logic             w_match;
  logic             w_arm;
  logic [PAT_W-1:0] w_hist_next;

  assign w_hunting   = (r_state == ST_FILL) || (r_state == ST_HUNT);
  assign w_accept    = w_hunting && bit_valid && !stop;
  assign w_hist_next = {r_history[PAT_W-2:0], bit_stream};
  // The bit that brings the window to PAT_W is already eligible for a match.
  assign w_complete  = (r_state == ST_HUNT) || (r_fill == c_FILL_LAST);
  assign w_match     = w_accept && w_complete &&
                       (((w_hist_next ^ r_pattern) & r_mask) == '0);
  assign w_arm       = (r_state == ST_IDLE) && start && !stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_history <= '0;
      r_fill    <= '0;
      r_pattern <= RST_PATTERN;
      r_mask    <= '1;
      r_mode    <= c_MODE_DEFAULT;
      r_found   <= 1'b0;
    end else begin
      r_found <= w_match;
      case (r_state)
        ST_IDLE: begin
          if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_mask    <= cfg_mask;
            r_mode    <= cfg_mode;
          end
          if (w_arm) begin
            r_state   <= ST_FILL;
            r_history <= '0;
            r_fill    <= '0;
          end
        end
        default: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (bit_valid) begin
            r_history <= w_hist_next;
            if (w_match) begin
              if (r_mode[c_MODE_ONESHOT]) begin
                r_state <= ST_IDLE;
              end else if (r_mode[c_MODE_OVERLAP]) begin
                r_state <= ST_HUNT;
                r_fill  <= c_FILL_FULL;
              end else begin
                r_state <= ST_FILL;
                r_fill  <= '0;
              end
            end else if (r_state == ST_FILL) begin
              r_fill <= r_fill + 1'b1;
              if (w_complete) begin
                r_state <= ST_HUNT;
              end
            end
          end
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_arm),
    .inc  (w_match),
    .count(match_count)
  );

  assign found = r_found;
  assign armed = w_hunting;

endmodule
`default_nettype wire

// File: tb/tb_pattern_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_det
// Description : Scoreboard bench for pattern_det (PAT_W = 4) with a
//               bit-queue reference model; a CNT_W = 2 copy covers saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_det;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_stream = 1'b0;
  logic             bit_valid = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [PAT_W-1:0] cfg_mask = '0;
  logic [1:0]       cfg_mode = '0;
  logic             found, found_s, armed, armed_s;
  logic [15:0]      match_count;
  logic [1:0]       match_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_det #(.PAT_W(PAT_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bit_stream(bit_stream), .bit_valid(bit_valid),
    .start(start), .stop(stop), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .found(found),
    .match_count(match_count), .armed(armed)
  );

  pattern_det #(.PAT_W(PAT_W), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .bit_stream(bit_stream), .bit_valid(bit_valid),
    .start(start), .stop(stop), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode), .found(found_s),
    .match_count(match_count_s), .armed(armed_s)
  );

  typedef struct {
    bit found;
    int cnt;
    bit armed;
  } exp_t;

  exp_t sb[$];

  // Reference model: the bits seen since arming (or since the last
  // non-overlapping match), trimmed to the most recent PAT_W.
  bit         m_armed = 0;
  bit         m_bits[$];
  logic [3:0] m_pat = 4'b0101;
  logic [3:0] m_mask = 4'hF;
  logic [1:0] m_mode = 2'b00;
  int         m_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic step(input logic rn, input logic st, input logic sp, input logic ld,
                      input logic [3:0] p, input logic [3:0] mk, input logic [1:0] md,
                      input logic bv, input logic b);
    exp_t       e;
    logic [3:0] win;
    bit         hit;
    @(negedge clk);
    rst_n = rn; start = st; stop = sp; cfg_load = ld;
    cfg_pattern = p; cfg_mask = mk; cfg_mode = md; bit_valid = bv; bit_stream = b;
    hit = 0;
    if (!rn) begin
      m_armed = 0; m_bits.delete(); m_cnt = 0;
      m_pat = 4'b0101; m_mask = 4'hF; m_mode = 2'b00;
      #1;
      chk("async_rst_found", int'(found), 0);
      chk("async_rst_armed", int'(armed), 0);
      chk("async_rst_count", int'(match_count), 0);
    end else if (!m_armed) begin
      if (ld) begin m_pat = p; m_mask = mk; m_mode = md; end
      if (st && !sp) begin m_armed = 1; m_bits.delete(); m_cnt = 0; end
    end else if (sp) begin
      m_armed = 0;
    end else if (bv) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_W) begin
        win = '0;
        foreach (m_bits[i]) win = {win[2:0], m_bits[i]};
        if (((win ^ m_pat) & m_mask) == 4'b0000) begin
          hit = 1;
          m_cnt++;
          if (m_mode[1]) m_armed = 0;
          else if (!m_mode[0]) m_bits.delete();
        end
      end
    end
    e.found = hit; e.cnt = m_cnt; e.armed = m_armed;
    sb.push_back(e);
  endtask

  task automatic feed(input logic b);
    step(1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, b);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0);
  endtask

  task automatic arm(input logic [3:0] p, input logic [3:0] mk, input logic [1:0] md);
    step(1, 1, 0, 1, p, mk, md, 0, 0);
  endtask

  task automatic disarm();
    step(1, 0, 1, 0, 4'h0, 4'h0, 2'b00, 0, 0);
  endtask

  // Monitor: one expected entry per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("found", int'(found), int'(e.found));
        chk("match_count", int'(match_count), sat(e.cnt, 65535));
        chk("armed", int'(armed), int'(e.armed));
        chk("found_sat", int'(found_s), int'(e.found));
        chk("match_count_sat", int'(match_count_s), sat(e.cnt, 3));
      end
    end
  end

  initial begin
    logic [3:0] stream;
    step(0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0);
    step(0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0);
    idle();

    // Overlapping 0101 over 0,1,0,1,0,1
    arm(4'b0101, 4'hF, 2'b01);
    for (int i = 0; i < 6; i++) feed(i[0]);
    idle(); disarm();

    // Same stream, non-overlapping
    arm(4'b0101, 4'hF, 2'b00);
    for (int i = 0; i < 6; i++) feed(i[0]);
    idle(); disarm();

    // One-shot with partial mask
    arm(4'b1000, 4'b1001, 2'b10);
    stream = 4'b1110;
    for (int i = 3; i >= 0; i--) feed(stream[i]);
    for (int i = 0; i < 4; i++) feed(1'b1);
    idle();

    // Gapped valid
    arm(4'b0101, 4'hF, 2'b00);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, ~i[0]);
      feed(i[0]);
    end
    idle(); idle(); disarm();

    // All-zero mask saturation
    arm(4'b1010, 4'h0, 2'b01);
    for (int i = 0; i < 10; i++) feed(1'($urandom_range(0, 1)));
    idle(); disarm();

    // Reset mid-operation, then default pattern
    arm(4'b1111, 4'hF, 2'b01);
    feed(0); feed(1); feed(0);
    step(0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1, 1);
    feed(1);
    step(1, 1, 0, 0, 4'h0, 4'h0, 2'b00, 0, 0);
    feed(0); feed(1); feed(0); feed(1);
    idle(); disarm();

    // Randomized traffic, including start/stop collisions and cfg_load while armed
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 23) == 0),
           ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end
    idle(); idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
